// File: rtl/arp_key_tagger.sv
// arp_key_tagger: inline AXI-Stream stage that overwrites a SOP-snapshotted key into frames matching ETHERTYPE
module arp_key_tagger #(
  parameter int          C_AXIS_DATA_WIDTH  = 256,
  parameter int          C_AXIS_TUSER_WIDTH = 128,
  parameter int          KEY_WORDS          = 4,
  parameter int          TAG_BEAT           = 1,
  parameter int          TAG_OFFSET         = 10,
  parameter logic [15:0] ETHERTYPE          = 16'h0806
) (
  input  logic                            axis_aclk,
  input  logic                            axis_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  input  logic                            tag_en,
  input  logic [32*KEY_WORDS-1:0]         key_in,
  input  logic                            clear_counters,
  output logic [31:0]                     match_cnt,
  output logic [31:0]                     tagged_cnt,
  output logic [31:0]                     short_cnt
);
  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int KB = C_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  localparam int NK = 4 * KEY_WORDS;
  localparam logic [3:0] TB = 4'(TAG_BEAT);
  typedef enum logic [1:0] {SOP, HUNT, PASS} state_t;
  state_t state_q, state_d;
  logic [3:0] beat_q, beat_d;
  logic [32*KEY_WORDS-1:0] key_q, key_d, key_use;
  logic [DW-1:0] data_q, data_d, tag_data;
  logic [KB-1:0] keep_q, keep_d, tag_keep;
  logic [UW-1:0] user_q, user_d;
  logic valid_q, valid_d, last_q, last_d;
  logic [31:0] match_q, match_d, tagged_q, tagged_d, short_q, short_d;
  logic in_fire, sop, hit, tag, short_end;
  assign s_axis_tready = ~valid_q | m_axis_tready;
  assign m_axis_tdata  = data_q;
  assign m_axis_tkeep  = keep_q;
  assign m_axis_tuser  = user_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_q;
  assign match_cnt     = match_q;
  assign tagged_cnt    = tagged_q;
  assign short_cnt     = short_q;
  always_comb begin
    in_fire = s_axis_tvalid & s_axis_tready;
    sop = state_q == SOP;
    hit = {s_axis_tdata[103:96], s_axis_tdata[111:104]} == ETHERTYPE;
    key_use = sop ? key_in : key_q;
    tag = sop ? hit & tag_en & (TAG_BEAT == 0) : (state_q == HUNT) & (beat_q == TB);
    short_end = s_axis_tlast & (sop ? hit & tag_en & (TAG_BEAT != 0) : (state_q == HUNT) & (beat_q != TB));
    tag_data = s_axis_tdata;
    tag_keep = s_axis_tkeep;
    for (int i = 0; i < NK; i++) begin
      tag_data[8*(TAG_OFFSET+i) +: 8] = key_use[8*i +: 8];
      tag_keep[TAG_OFFSET+i] = 1'b1;
    end
  end
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    key_d = key_q;
    if (in_fire) begin
      if (sop) begin
        beat_d = 4'd1;
        key_d = key_in;
        state_d = s_axis_tlast ? SOP : (hit & tag_en & (TAG_BEAT != 0)) ? HUNT : PASS;
      end else if (state_q == HUNT) begin
        state_d = s_axis_tlast ? SOP : tag ? PASS : HUNT;
        beat_d = tag ? beat_q : beat_q + 4'd1;
      end else begin
        state_d = s_axis_tlast ? SOP : PASS;
      end
    end
    valid_d = in_fire | (valid_q & ~m_axis_tready);
    data_d = in_fire ? (tag ? tag_data : s_axis_tdata) : data_q;
    keep_d = in_fire ? (tag ? tag_keep : s_axis_tkeep) : keep_q;
    user_d = in_fire ? s_axis_tuser : user_q;
    last_d = in_fire ? s_axis_tlast : last_q;
    match_d = clear_counters ? 32'd0 : match_q + 32'(in_fire & sop & hit);
    tagged_d = clear_counters ? 32'd0 : tagged_q + 32'(in_fire & tag);
    short_d = clear_counters ? 32'd0 : short_q + 32'(in_fire & short_end);
  end
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q <= SOP;
      beat_q <= '0;
      key_q <= '0;
      data_q <= '0;
      keep_q <= '0;
      user_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      match_q <= '0;
      tagged_q <= '0;
      short_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      key_q <= key_d;
      data_q <= data_d;
      keep_q <= keep_d;
      user_q <= user_d;
      valid_q <= valid_d;
      last_q <= last_d;
      match_q <= match_d;
      tagged_q <= tagged_d;
      short_q <= short_d;
    end
  end
endmodule

// File: tb/tb_arp_key_tagger.sv
// tb_arp_key_tagger: randomized scoreboard bench for arp_key_tagger against a frame-level reference model
module tb_arp_key_tagger;
  localparam int DW = 256, UW = 128, KW = 4, TBEAT = 1, TOFF = 10, NB = DW / 8;
  localparam logic [15:0] ARP = 16'h0806;
  typedef struct packed {logic [DW-1:0] d; logic [NB-1:0] k; logic [UW-1:0] u; logic l;} beat_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [DW-1:0] s_data = '0, m_data;
  logic [NB-1:0] s_keep = '0, m_keep;
  logic [UW-1:0] s_user = '0, m_user;
  logic s_valid = 1'b0, s_ready, s_last = 1'b0, m_valid, m_ready = 1'b0, m_last;
  logic tag_en = 1'b0, clr = 1'b0;
  logic [32*KW-1:0] key_in = '0;
  logic [31:0] match_cnt, tagged_cnt, short_cnt;
  beat_t exp_q[$];
  beat_t got, e;
  int total = 0, bad = 0;
  int e_match = 0, e_tag = 0, e_short = 0;
  bit rand_ready = 1'b0, force_ready = 1'b1;
  arp_key_tagger dut (
    .axis_aclk(clk), .axis_reset(rst),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tuser(s_user),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tlast(s_last),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tuser(m_user),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tlast(m_last),
    .tag_en(tag_en), .key_in(key_in), .clear_counters(clr),
    .match_cnt(match_cnt), .tagged_cnt(tagged_cnt), .short_cnt(short_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : force_ready;
  end
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      total++;
      got = {m_data, m_keep, m_user, m_last};
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat got data=%h last=%b", m_data, m_last);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL beat got data=%h keep=%h user=%h last=%b want data=%h keep=%h user=%h last=%b",
                   got.d, got.k, got.u, got.l, e.d, e.k, e.u, e.l);
        end
      end
    end
  end
  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction
  function automatic logic [UW-1:0] rnd_user();
    logic [UW-1:0] r;
    for (int i = 0; i < UW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction
  function automatic logic [32*KW-1:0] rnd_key();
    logic [32*KW-1:0] r;
    for (int i = 0; i < KW; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask
  task automatic put_beat(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic [UW-1:0] u, input logic l);
    int n = 0;
    s_data = d; s_keep = k; s_user = u; s_last = l; s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) chk("s_tready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask
  task automatic send_frame(input int nb, input logic [15:0] et, input logic en, input logic [32*KW-1:0] key0,
                            input bit churn, input bit gaps, input int clr_beat);
    logic [DW-1:0] d;
    logic [NB-1:0] k;
    logic [UW-1:0] u;
    beat_t x;
    bit hit;
    hit = et == ARP;
    tag_en = en;
    key_in = key0;
    if (hit) e_match++;
    if (hit && en) begin
      if (nb > TBEAT) e_tag++;
      else e_short++;
    end
    for (int i = 0; i < nb; i++) begin
      d = rnd_data();
      u = rnd_user();
      k = (i == nb - 1) ? NB'({$urandom, $urandom} | 64'd1) : '1;
      if (i == 0) begin
        d[8*12 +: 8] = et[15:8];
        d[8*13 +: 8] = et[7:0];
      end
      if (churn && i > 0) begin
        key_in = rnd_key();
        tag_en = 1'($urandom_range(0, 1));
      end
      x = {d, k, u, i == nb - 1};
      if (hit && en && i == TBEAT)
        for (int j = 0; j < 4 * KW; j++) begin
          x.d[8*(TOFF+j) +: 8] = key0[8*j +: 8];
          x.k[TOFF+j] = 1'b1;
        end
      exp_q.push_back(x);
      clr = i == clr_beat;
      put_beat(d, k, u, i == nb - 1);
      clr = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    if (clr_beat >= 0) begin
      e_match = 0; e_tag = 0; e_short = 0;
    end
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      n++;
      @(posedge clk);
    end
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic chk_cnts(input string tag);
    chk({tag, "_match"}, match_cnt, e_match);
    chk({tag, "_tagged"}, tagged_cnt, e_tag);
    chk({tag, "_short"}, short_cnt, e_short);
  endtask
  initial begin
    logic [31:0] base;
    logic [DW-1:0] d;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data_lo", m_data[31:0], 0);
    chk("rst_last", 32'(m_last), 0);
    chk_cnts("rst");
    rst = 1'b0;
    send_frame(3, ARP, 1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 0, 0, -1);
    drain();
    chk_cnts("arp_tag");
    chk("arp_tag_abs", tagged_cnt, 1);
    send_frame(4, 16'h0800, 1'b1, rnd_key(), 0, 0, -1);
    drain();
    chk_cnts("ipv4");
    send_frame(3, ARP, 1'b0, rnd_key(), 0, 0, -1);
    drain();
    chk_cnts("arp_off");
    send_frame(1, ARP, 1'b1, rnd_key(), 0, 0, -1);
    drain();
    chk_cnts("short");
    chk("short_abs", short_cnt, 1);
    rand_ready = 1'b1;
    base = tagged_cnt;
    for (int f = 0; f < 100; f++) send_frame($urandom_range(2, 5), ARP, 1'b1, rnd_key(), 1, 1, -1);
    drain();
    chk_cnts("burst");
    chk("burst_100", tagged_cnt - base, 100);
    for (int f = 0; f < 40; f++)
      send_frame($urandom_range(1, 4), $urandom_range(0, 1) ? ARP : 16'(16'h0800 + $urandom_range(0, 8)),
                 1'($urandom_range(0, 1)), rnd_key(), 1, 1, -1);
    drain();
    chk_cnts("mixed");
    rand_ready = 1'b0;
    force_ready = 1'b1;
    send_frame(3, ARP, 1'b1, rnd_key(), 0, 0, 1);
    drain();
    chk_cnts("clear");
    force_ready = 1'b0;
    @(posedge clk);
    #1;
    d = rnd_data();
    d[8*12 +: 8] = 8'h08;
    d[8*13 +: 8] = 8'h06;
    tag_en = 1'b1;
    put_beat(d, '1, rnd_user(), 1'b0);
    chk("midrst_held", 32'(m_valid), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_valid", 32'(m_valid), 0);
    e_match = 0; e_tag = 0; e_short = 0;
    force_ready = 1'b1;
    send_frame(2, ARP, 1'b1, rnd_key(), 0, 0, -1);
    drain();
    chk_cnts("after_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
